// File: rtl/sha256_seq_pkg.sv
// ----------------------------------------------------------------------------
// sha256_seq_pkg
// Shared constants and types for the SHA-256 block sequencer.
//   seq_state_e    : sequencer FSM state encoding (IDLE, LOAD, KICK, RUN)
//   WORDS_PER_BLOCK: 32-bit words per 512-bit message block
//   TIMEOUT_CYCLES : RUN cycles allowed without core_done before the watchdog
//                    abandons the message
// ----------------------------------------------------------------------------
package sha256_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_KICK = 2'd2,
    ST_RUN  = 2'd3
  } seq_state_e;

  localparam int WORDS_PER_BLOCK = 16;
  localparam int TIMEOUT_CYCLES  = 1024;

  localparam int WORD_CNT_W = $clog2(WORDS_PER_BLOCK);
  localparam int WD_CNT_W   = $clog2(TIMEOUT_CYCLES);

  // Terminal counts, pre-sized so comparisons stay width-matched.
  localparam logic [WORD_CNT_W-1:0] LAST_WORD = WORD_CNT_W'(WORDS_PER_BLOCK - 1);
  localparam logic [WD_CNT_W-1:0]   WD_LAST   = WD_CNT_W'(TIMEOUT_CYCLES - 1);

endpackage

// File: rtl/sha256_block_sequencer_if.sv
// ----------------------------------------------------------------------------
// sha256_block_sequencer_if
// Bundles the message-word stream, the compression-core side and the status
// outputs of the sequencer.
//   Stream in : start, abort, num_blocks, in_data, in_valid -> in_ready
//   Core side : core_word, core_word_addr, core_we, core_start, core_first
//               <- core_done, core_hash
//   Status    : busy, done, hash_out, timeout
// Modports:
//   slave  - the sequencer itself
//   master - the environment driving the sequencer (host + core)
// ----------------------------------------------------------------------------
interface sha256_block_sequencer_if;

  logic         start;
  logic         abort;
  logic [7:0]   num_blocks;
  logic [31:0]  in_data;
  logic         in_valid;
  logic         in_ready;

  logic [31:0]  core_word;
  logic [3:0]   core_word_addr;
  logic         core_we;
  logic         core_start;
  logic         core_first;
  logic         core_done;
  logic [255:0] core_hash;

  logic         busy;
  logic         done;
  logic [255:0] hash_out;
  logic         timeout;

  modport slave (
    input  start, abort, num_blocks, in_data, in_valid, core_done, core_hash,
    output in_ready, core_word, core_word_addr, core_we, core_start,
           core_first, busy, done, hash_out, timeout
  );

  modport master (
    output start, abort, num_blocks, in_data, in_valid, core_done, core_hash,
    input  in_ready, core_word, core_word_addr, core_we, core_start,
           core_first, busy, done, hash_out, timeout
  );

endinterface

// File: rtl/sha256_block_sequencer.sv
// ----------------------------------------------------------------------------
// sha256_block_sequencer
// Feeds a multi-block message into a SHA-256 compression core one 512-bit
// block at a time: streams 16 words into the core's schedule memory, kicks the
// core, waits for it, and repeats until num_blocks blocks are done. The final
// digest is captured in hash_out and announced with a one-cycle done pulse.
// A watchdog abandons the message if the core never answers.
// Ports:
//   clk     - rising-edge system clock
//   reset_n - asynchronous active-low reset
//   bus     - sha256_block_sequencer_if.slave (stream, core and status signals)
// ----------------------------------------------------------------------------
module sha256_block_sequencer
  import sha256_seq_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset_n,
  sha256_block_sequencer_if.slave   bus
);

  seq_state_e              state_q, state_d;
  logic [7:0]              nblk_q, nblk_d;
  logic [7:0]              blk_cnt_q, blk_cnt_d;
  logic [WORD_CNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic [WD_CNT_W-1:0]     wd_cnt_q, wd_cnt_d;
  logic                    core_first_q, core_first_d;
  logic                    core_start_q, core_start_d;
  logic                    done_q, done_d;
  logic                    timeout_q, timeout_d;
  logic [255:0]            hash_q, hash_d;

  logic                    in_load;
  logic                    accept;
  logic                    last_block;

  assign in_load    = (state_q == ST_LOAD);
  assign accept     = in_load && bus.in_valid;
  // Widened so num_blocks = 255 cannot wrap the comparison.
  assign last_block = ({1'b0, blk_cnt_q} + 9'd1) == {1'b0, nblk_q};

  always_comb begin
    state_d      = state_q;
    nblk_d       = nblk_q;
    blk_cnt_d    = blk_cnt_q;
    word_cnt_d   = word_cnt_q;
    wd_cnt_d     = wd_cnt_q;
    core_first_d = core_first_q;
    core_start_d = 1'b0;
    done_d       = 1'b0;
    timeout_d    = timeout_q;
    hash_d       = hash_q;

    if (bus.abort) begin
      // Cancel wins over every other transition; the last good digest and
      // the sticky timeout flag are preserved.
      state_d      = ST_IDLE;
      blk_cnt_d    = '0;
      word_cnt_d   = '0;
      wd_cnt_d     = '0;
      core_first_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.start && (bus.num_blocks != 8'd0)) begin
            nblk_d       = bus.num_blocks;
            blk_cnt_d    = '0;
            word_cnt_d   = '0;
            timeout_d    = 1'b0;
            core_first_d = 1'b1;
            state_d      = ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (accept) begin
            if (word_cnt_q == LAST_WORD) begin
              word_cnt_d   = '0;
              state_d      = ST_KICK;
              // Registered so the pulse coincides exactly with the KICK cycle.
              core_start_d = 1'b1;
            end else begin
              word_cnt_d = word_cnt_q + 1'b1;
            end
          end
        end
        ST_KICK: begin
          wd_cnt_d = '0;
          state_d  = ST_RUN;
        end
        ST_RUN: begin
          if (bus.core_done) begin
            if (last_block) begin
              hash_d    = bus.core_hash;
              done_d    = 1'b1;
              blk_cnt_d = '0;
              state_d   = ST_IDLE;
            end else begin
              blk_cnt_d    = blk_cnt_q + 8'd1;
              core_first_d = 1'b0;
              state_d      = ST_LOAD;
            end
          end else if (wd_cnt_q == WD_LAST) begin
            // Core answered on none of the allowed cycles: give up silently.
            timeout_d = 1'b1;
            wd_cnt_d  = '0;
            blk_cnt_d = '0;
            state_d   = ST_IDLE;
          end else begin
            wd_cnt_d = wd_cnt_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      nblk_q       <= '0;
      blk_cnt_q    <= '0;
      word_cnt_q   <= '0;
      wd_cnt_q     <= '0;
      core_first_q <= 1'b0;
      core_start_q <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      hash_q       <= '0;
    end else begin
      state_q      <= state_d;
      nblk_q       <= nblk_d;
      blk_cnt_q    <= blk_cnt_d;
      word_cnt_q   <= word_cnt_d;
      wd_cnt_q     <= wd_cnt_d;
      core_first_q <= core_first_d;
      core_start_q <= core_start_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
      hash_q       <= hash_d;
    end
  end

  // Write path is combinational so a word lands in the schedule memory in the
  // same cycle it is accepted. Outside LOAD the word/address are forced to 0
  // so every output reads 0 while idle or in reset.
  assign bus.in_ready       = in_load;
  assign bus.core_we        = accept;
  assign bus.core_word      = in_load ? bus.in_data : 32'h0;
  assign bus.core_word_addr = in_load ? word_cnt_q : 4'h0;
  assign bus.core_start     = core_start_q;
  assign bus.core_first     = core_first_q;
  assign bus.busy           = (state_q != ST_IDLE);
  assign bus.done           = done_q;
  assign bus.hash_out       = hash_q;
  assign bus.timeout        = timeout_q;

endmodule

// File: tb/tb_sha256_block_sequencer.sv
// ----------------------------------------------------------------------------
// tb_sha256_block_sequencer
// Directed bench for sha256_block_sequencer. The environment plays both the
// message source and the compression core; expected values are hand-derived.
// ----------------------------------------------------------------------------
module tb_sha256_block_sequencer;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  sha256_block_sequencer_if bus();

  sha256_block_sequencer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int kick_cnt = 0;

  logic [31:0]  words [16];
  logic [255:0] last_hash;

  // Pulse counters, sampled at the edge so they see the pre-edge values.
  always @(posedge clk) begin
    if (bus.done === 1'b1) done_cnt++;
    if (bus.core_start === 1'b1) kick_cnt++;
  end

  // Global safety net against any unforeseen stall.
  initial begin
    #1000000;
    $display("FAIL global_timeout: got simulation still running want finished");
    $fatal(1, "bench did not complete");
  end

  // Presents one word (after an optional in_valid gap) and checks the write.
  task automatic send_word(input int idx, input logic [31:0] w, input int gap);
    bus.in_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      #1;
      checks++;
      if (bus.core_we !== 1'b0 || bus.core_word_addr !== 4'(idx)) begin
        errors++;
        $display("FAIL gap_hold: got we=%0b addr=%0d want we=0 addr=%0d",
                 bus.core_we, bus.core_word_addr, idx);
      end
      @(negedge clk);
    end
    bus.in_data  = w;
    bus.in_valid = 1'b1;
    #1;
    checks++;
    if (bus.core_we !== 1'b1 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL word_we: got we=%0b ready=%0b want 1/1", bus.core_we, bus.in_ready);
    end
    checks++;
    if (bus.core_word_addr !== 4'(idx)) begin
      errors++;
      $display("FAIL word_addr: got %0d want %0d", bus.core_word_addr, idx);
    end
    checks++;
    if (bus.core_word !== w) begin
      errors++;
      $display("FAIL word_data: got %h want %h", bus.core_word, w);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = 32'h0;
  endtask

  task automatic start_msg(input logic [7:0] n);
    bus.start      = 1'b1;
    bus.num_blocks = n;
    @(negedge clk);
    bus.start      = 1'b0;
    bus.num_blocks = 8'd0;
    checks++;
    if (bus.busy !== 1'b1 || bus.in_ready !== 1'b1 || bus.core_word_addr !== 4'd0) begin
      errors++;
      $display("FAIL start_accept: got busy=%0b ready=%0b addr=%0d want 1/1/0",
               bus.busy, bus.in_ready, bus.core_word_addr);
    end
    checks++;
    if (bus.core_first !== 1'b1 || bus.timeout !== 1'b0) begin
      errors++;
      $display("FAIL start_flags: got first=%0b timeout=%0b want 1/0",
               bus.core_first, bus.timeout);
    end
  endtask

  // Streams all 16 words; returns at the first RUN cycle.
  task automatic load_block(input int max_gap, input logic exp_first);
    for (int i = 0; i < 16; i++) begin
      send_word(i, words[i], (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap)));
    end
    checks++;
    if (bus.core_start !== 1'b1 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL kick: got core_start=%0b ready=%0b want 1/0", bus.core_start, bus.in_ready);
    end
    checks++;
    if (bus.core_first !== exp_first) begin
      errors++;
      $display("FAIL kick_first: got %0b want %0b", bus.core_first, exp_first);
    end
    @(negedge clk);
    checks++;
    if (bus.core_start !== 1'b0 || bus.busy !== 1'b1 || bus.in_ready !== 1'b0 ||
        bus.core_we !== 1'b0) begin
      errors++;
      $display("FAIL run_entry: got start=%0b busy=%0b ready=%0b we=%0b want 0/1/0/0",
               bus.core_start, bus.busy, bus.in_ready, bus.core_we);
    end
  endtask

  task automatic finish_block(input int wait_cycles, input logic [255:0] h, input logic last);
    repeat (wait_cycles) @(negedge clk);
    bus.core_done = 1'b1;
    bus.core_hash = h;
    @(negedge clk);
    bus.core_done = 1'b0;
    bus.core_hash = '0;
    if (last) begin
      checks++;
      if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL done_pulse: got done=%0b busy=%0b want 1/0", bus.done, bus.busy);
      end
      checks++;
      if (bus.hash_out !== h) begin
        errors++;
        $display("FAIL hash_out: got %h want %h", bus.hash_out, h);
      end
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b0 || bus.hash_out !== h) begin
        errors++;
        $display("FAIL done_hold: got done=%0b hash=%h want 0/%h", bus.done, bus.hash_out, h);
      end
      last_hash = h;
      $display("message complete: hash_out=%h", bus.hash_out);
    end else begin
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b1 || bus.in_ready !== 1'b1 ||
          bus.core_first !== 1'b0 || bus.core_word_addr !== 4'd0) begin
        errors++;
        $display("FAIL next_block: got done=%0b busy=%0b ready=%0b first=%0b addr=%0d want 0/1/1/0/0",
                 bus.done, bus.busy, bus.in_ready, bus.core_first, bus.core_word_addr);
      end
      $display("block complete, loading next");
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.abort = 1'b0; bus.num_blocks = 8'd0;
    bus.in_data = 32'h0; bus.in_valid = 1'b0;
    bus.core_done = 1'b0; bus.core_hash = '0;
    #3;
    checks++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0 || bus.core_start !== 1'b0 ||
        bus.core_first !== 1'b0 || bus.done !== 1'b0 || bus.timeout !== 1'b0 ||
        bus.core_we !== 1'b0 || bus.hash_out !== 256'h0) begin
      errors++;
      $display("FAIL reset_state: got busy=%0b ready=%0b start=%0b first=%0b done=%0b to=%0b hash=%h want all 0",
               bus.busy, bus.in_ready, bus.core_start, bus.core_first, bus.done,
               bus.timeout, bus.hash_out);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got busy=%0b want 0", bus.busy);
    end
    $display("reset released");
  endtask

  task automatic test_single_block();
    int d0, k0;
    logic [255:0] h;
    h = {32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
         32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
    for (int i = 0; i < 16; i++) words[i] = 32'h0;
    words[0]  = 32'h61626380;
    words[15] = 32'h00000018;
    d0 = done_cnt; k0 = kick_cnt;
    start_msg(8'd1);
    load_block(0, 1'b1);
    finish_block(64, h, 1'b1);
    checks++;
    if (done_cnt - d0 !== 1 || kick_cnt - k0 !== 1) begin
      errors++;
      $display("FAIL single_counts: got done=%0d kicks=%0d want 1/1", done_cnt - d0, kick_cnt - k0);
    end
  endtask

  task automatic test_multi_block();
    int d0, k0;
    logic [255:0] h;
    d0 = done_cnt; k0 = kick_cnt;
    start_msg(8'd3);
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 16; i++) words[i] = 32'h1000_0000 * (b + 1) + i;
      h = {8{32'hA5A5_0000 + b}};
      load_block(2, (b == 0) ? 1'b1 : 1'b0);
      finish_block(5 + b, h, (b == 2) ? 1'b1 : 1'b0);
      if (b < 2) begin
        checks++;
        if (done_cnt - d0 !== 0) begin
          errors++;
          $display("FAIL early_done: got %0d done pulses want 0 after block %0d", done_cnt - d0, b);
        end
      end
    end
    checks++;
    if (done_cnt - d0 !== 1 || kick_cnt - k0 !== 3) begin
      errors++;
      $display("FAIL multi_counts: got done=%0d kicks=%0d want 1/3", done_cnt - d0, kick_cnt - k0);
    end
  endtask

  task automatic test_ignored_start();
    logic [255:0] h;
    h = {8{32'h0BAD_F00D}};
    bus.start = 1'b1; bus.num_blocks = 8'd0;
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL zero_blocks: got busy=%0b ready=%0b want 0/0", bus.busy, bus.in_ready);
    end
    // core_done while idle must not touch the digest.
    bus.core_done = 1'b1; bus.core_hash = h;
    @(negedge clk);
    bus.core_done = 1'b0; bus.core_hash = '0;
    checks++;
    if (bus.done !== 1'b0 || bus.hash_out !== last_hash || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_core_done: got done=%0b busy=%0b hash=%h want 0/0/%h",
               bus.done, bus.busy, bus.hash_out, last_hash);
    end
    for (int i = 0; i < 16; i++) words[i] = 32'hC0DE_0000 + i;
    start_msg(8'd1);
    load_block(0, 1'b1);
    // A second start in RUN (asking for 5 blocks) must not extend the message.
    bus.start = 1'b1; bus.num_blocks = 8'd5;
    @(negedge clk);
    bus.start = 1'b0; bus.num_blocks = 8'd0;
    checks++;
    if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0 || bus.core_start !== 1'b0) begin
      errors++;
      $display("FAIL start_in_run: got busy=%0b ready=%0b kick=%0b want 1/0/0",
               bus.busy, bus.in_ready, bus.core_start);
    end
    finish_block(3, {8{32'h5555_AAAA}}, 1'b1);
  endtask

  task automatic test_abort();
    int d0;
    logic [255:0] prev;
    prev = last_hash;
    d0 = done_cnt;
    for (int i = 0; i < 16; i++) words[i] = 32'hAB00_0000 + i;
    start_msg(8'd1);
    for (int i = 0; i < 8; i++) send_word(i, words[i], 0);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: got busy=%0b ready=%0b done=%0b want 0/0/0",
               bus.busy, bus.in_ready, bus.done);
    end
    checks++;
    if (bus.hash_out !== prev) begin
      errors++;
      $display("FAIL abort_hash: got %h want %h", bus.hash_out, prev);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (done_cnt - d0 !== 0) begin
      errors++;
      $display("FAIL abort_done: got %0d done pulses want 0", done_cnt - d0);
    end
    $display("message aborted after word 7");
    // Fresh message must start writing at address 0 again.
    start_msg(8'd1);
    load_block(0, 1'b1);
    finish_block(2, {8{32'h1234_5678}}, 1'b1);
  endtask

  task automatic test_timeout();
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < 16; i++) words[i] = 32'h7100_0000 + i;
    start_msg(8'd1);
    load_block(0, 1'b1);
    // First RUN cycle observed here; the 1024th RUN cycle trips the watchdog.
    repeat (1023) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1 || bus.timeout !== 1'b0) begin
      errors++;
      $display("FAIL wd_early: got busy=%0b timeout=%0b want 1/0", bus.busy, bus.timeout);
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.timeout !== 1'b1 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL wd_fire: got busy=%0b timeout=%0b done=%0b want 0/1/0",
               bus.busy, bus.timeout, bus.done);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (bus.timeout !== 1'b1 || done_cnt - d0 !== 0 || bus.hash_out !== last_hash) begin
      errors++;
      $display("FAIL wd_sticky: got timeout=%0b dones=%0d want 1/0", bus.timeout, done_cnt - d0);
    end
    $display("watchdog expired, timeout flagged");
    // Next accepted start clears the flag (checked in start_msg).
    start_msg(8'd1);
    load_block(0, 1'b1);
    finish_block(10, {8{32'h0F0F_F0F0}}, 1'b1);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 16; i++) words[i] = 32'hEE00_0000 + i;
    start_msg(8'd1);
    load_block(0, 1'b1);
    repeat (10) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.hash_out !== 256'h0 || bus.core_first !== 1'b0 ||
        bus.timeout !== 1'b0 || bus.in_ready !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got busy=%0b first=%0b to=%0b ready=%0b hash=%h want all 0",
               bus.busy, bus.core_first, bus.timeout, bus.in_ready, bus.hash_out);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    $display("reset asserted mid-RUN, restarting");
    start_msg(8'd1);
    load_block(1, 1'b1);
    finish_block(4, {8{32'h3C3C_C3C3}}, 1'b1);
  endtask

  initial begin
    last_hash = '0;
    test_reset();
    test_single_block();
    test_multi_block();
    test_ignored_start();
    test_abort();
    test_timeout();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sha256_block_sequencer.md
SHA256_BLOCK_SEQUENCER -- requirements
Module: sha256_block_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock, rising-edge.
REQ-002 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port start, input, 1 bit: begin message, sampled only in IDLE.
REQ-004 SHALL have port abort, input, 1 bit: synchronous cancel, any state.
REQ-005 SHALL have port num_blocks, input, 8 bits: 512-bit blocks in message, latched on accepted start.
REQ-006 SHALL have port in_data, input, 32 bits: message word.
REQ-007 SHALL have port in_valid, input, 1 bit: in_data valid.
REQ-008 SHALL have port in_ready, output, 1 bit: sequencer accepts a word.
REQ-009 SHALL have port core_word, output, 32 bits: word to schedule memory.
REQ-010 SHALL have port core_word_addr, output, 4 bits: word index 0-15.
REQ-011 SHALL have port core_we, output, 1 bit: schedule memory write strobe.
REQ-012 SHALL have port core_start, output, 1 bit: one-cycle compression start pulse.
REQ-013 SHALL have port core_first, output, 1 bit: 1 = core uses IV, 0 = core chains previous hash.
REQ-014 SHALL have port core_done, input, 1 bit: block compression finished.
REQ-015 SHALL have port core_hash, input, 256 bits: core digest.
REQ-016 SHALL have port busy, output, 1 bit: state != IDLE.
REQ-017 SHALL have port done, output, 1 bit: one-cycle message-complete pulse.
REQ-018 SHALL have port hash_out, output, 256 bits: final digest, held until next done.
REQ-019 SHALL have port timeout, output, 1 bit: sticky watchdog flag.

Function
REQ-020 States SHALL be IDLE, LOAD, KICK, RUN.
REQ-021 IDLE: start=1 and num_blocks!=0 SHALL latch num_blocks, clear blk_cnt, word_cnt, and timeout, set core_first=1, and enter LOAD; start with num_blocks=0 SHALL be ignored.
REQ-022 LOAD: in_ready SHALL be 1; core_we=in_valid&in_ready, core_word=in_data, core_word_addr=word_cnt combinationally; each accepted word SHALL increment word_cnt.
REQ-023 Acceptance of word 15 SHALL enter KICK, wrapping word_cnt to 0; in_valid gaps SHALL not skip or repeat addresses.
REQ-024 KICK SHALL last exactly one cycle with core_start=1 (registered), then enter RUN.
REQ-025 RUN: in_ready=0; on core_done, blk_cnt+1==latched num_blocks SHALL register hash_out<=core_hash, pulse done next cycle, and enter IDLE; otherwise blk_cnt increments, core_first<=0, and the state enters LOAD.
REQ-026 core_done outside RUN SHALL be ignored; start outside IDLE SHALL be ignored.
REQ-027 Watchdog: RUN cycles without core_done reaching TIMEOUT_CYCLES (1024) SHALL set timeout and enter IDLE without done.
REQ-028 abort SHALL take priority over all transitions: enter IDLE next cycle, no done, hash_out unchanged, counters cleared.
REQ-029 in_ready, core_we, and core_start SHALL be 0 in IDLE and RUN.

Reset
REQ-030 reset_n=0 SHALL force IDLE, counters 0, all outputs 0 (hash_out 256'h0) immediately, independent of clk, including mid-LOAD/RUN.

Structure
REQ-031 Package sha256_seq_pkg SHALL hold the state encoding, WORDS_PER_BLOCK=16, and TIMEOUT_CYCLES=1024.
REQ-032 The block SHALL be a single module; no sub-module is required.

Verification
REQ-033 Stimulus: num_blocks=1; words 0x61626380, 14x0x00000000, 0x00000018; core_done after 64 cycles with H. Required response: 16 writes at addr 0-15; core_start one cycle after the 16th accept with core_first=1; done pulse; hash_out=H.
REQ-034 Stimulus: num_blocks=3 with random in_valid gaps. Required response: 3 core_start pulses; core_first=1 only for block 0; one done, after the third core_done.
REQ-035 Stimulus: start with num_blocks=0; start during RUN. Required response: no state change; busy unaffected.
REQ-036 Stimulus: abort after word 7. Required response: IDLE next cycle, no done; next message writes from addr 0.
REQ-037 Stimulus: core_done withheld for 1024 RUN cycles. Required response: timeout=1, IDLE, no done.
REQ-038 Stimulus: reset_n low mid-RUN. Required response: all outputs 0 asynchronously; clean restart after release.
